// File: rtl/proc_io_hub_if.sv
// proc_io_hub_if
//  Groups the processor I/O bus, the producer-side input channels and the
//  registered output channels of proc_io_hub into one bundle.
//  Signals:
//   io_in       word returned to the core for the current addr_in
//   addr_in     core input address
//   req_in      core input-read strobe
//   io_out      core output word
//   addr_out    core output address
//   out_en      core output-write strobe
//   ch_in_data  producer words, channel i at [i*NBDATA +: NBDATA]
//   ch_in_vld   producer strobes, one per channel
//   ch_in_fresh per-channel "not yet read" flags
//   ch_out_data registered output words, channel k at [k*NBDATA +: NBDATA]
//   ch_out_stb  per-channel one-cycle update pulses
//   ovf_cnt     per-channel saturating overrun counters, channel i at [i*NBOVF +: NBOVF]
//   ovf_clr     clear-all pulse for the overrun counters
//  Modports: slave = the hub, master = the core/producer/consumer side.
interface proc_io_hub_if #(
  parameter int NBDATA = 23,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int NBOVF  = 8
);
  localparam int AWIN = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int AWOU = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  logic [NBDATA-1:0]        io_in;
  logic [AWIN-1:0]          addr_in;
  logic                     req_in;
  logic [NBDATA-1:0]        io_out;
  logic [AWOU-1:0]          addr_out;
  logic                     out_en;
  logic [NUIOIN*NBDATA-1:0] ch_in_data;
  logic [NUIOIN-1:0]        ch_in_vld;
  logic [NUIOIN-1:0]        ch_in_fresh;
  logic [NUIOOU*NBDATA-1:0] ch_out_data;
  logic [NUIOOU-1:0]        ch_out_stb;
  logic [NUIOIN*NBOVF-1:0]  ovf_cnt;
  logic                     ovf_clr;

  modport slave (
    input  addr_in, req_in, io_out, addr_out, out_en,
           ch_in_data, ch_in_vld, ovf_clr,
    output io_in, ch_in_fresh, ch_out_data, ch_out_stb, ovf_cnt
  );

  modport master (
    output addr_in, req_in, io_out, addr_out, out_en,
           ch_in_data, ch_in_vld, ovf_clr,
    input  io_in, ch_in_fresh, ch_out_data, ch_out_stb, ovf_cnt
  );
endinterface

// File: rtl/proc_io_hub.sv
// proc_io_hub
//  I/O scheduler between the proc_fl soft core I/O bus and its peripherals.
//  Producers drop samples into per-channel holding registers; the core reads
//  them back with zero latency. Each input channel tracks whether its sample
//  has been read (fresh) and counts overruns (a new sample arriving over an
//  unread one). Core writes are demultiplexed into registered output channels,
//  each with a one-cycle update strobe.
//  Ports:
//   clk  system clock, everything on the rising edge
//   rst  synchronous active-high reset, dominant over all other inputs
//   bus  proc_io_hub_if.slave carrying the core bus and the channel signals
module proc_io_hub #(
  parameter int NBDATA = 23,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int NBOVF  = 8
) (
  input logic           clk,
  input logic           rst,
  proc_io_hub_if.slave  bus
);
  localparam int AWIN = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int AWOU = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
  localparam logic [NBOVF-1:0] OVF_MAX = '1;

  logic [NBDATA-1:0] hold_q [NUIOIN];
  logic [NBDATA-1:0] hold_d [NUIOIN];
  logic [NUIOIN-1:0] fresh_q, fresh_d;
  logic [NBOVF-1:0]  ovf_q  [NUIOIN];
  logic [NBOVF-1:0]  ovf_d  [NUIOIN];
  logic [NBDATA-1:0] out_q  [NUIOOU];
  logic [NBDATA-1:0] out_d  [NUIOOU];
  logic [NUIOOU-1:0] stb_q, stb_d;

  logic [NUIOIN-1:0]        rd_hit;
  logic [NBDATA-1:0]        rd_data;
  logic [NUIOIN*NBOVF-1:0]  ovf_pk;
  logic [NUIOOU*NBDATA-1:0] out_pk;

  // Read mux and read decode. Addresses with no matching channel fall through
  // the loop untouched, so they return 0 and never clear a fresh flag.
  always_comb begin
    rd_data = '0;
    rd_hit  = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      if (bus.addr_in == AWIN'(i)) begin
        rd_data   = hold_q[i];
        rd_hit[i] = bus.req_in;
      end
    end
  end

  // Input capture. A new sample always wins the holding register and leaves the
  // channel fresh; it only counts as an overrun when the previous sample was
  // still unread and is not being read on this very cycle. The clear pulse is
  // applied last so it beats a coincident overrun.
  always_comb begin
    hold_d  = hold_q;
    fresh_d = fresh_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < NUIOIN; i++) begin
      if (bus.ch_in_vld[i]) begin
        hold_d[i]  = bus.ch_in_data[i*NBDATA +: NBDATA];
        fresh_d[i] = 1'b1;
        if (fresh_q[i] && !rd_hit[i] && (ovf_q[i] != OVF_MAX)) begin
          ovf_d[i] = ovf_q[i] + 1'b1;
        end
      end else if (rd_hit[i]) begin
        fresh_d[i] = 1'b0;
      end
      if (bus.ovf_clr) begin
        ovf_d[i] = '0;
      end
    end
  end

  // Output demux. Strobes default low every cycle, so a strobe lasts exactly
  // as long as consecutive writes keep hitting the same channel.
  always_comb begin
    out_d = out_q;
    stb_d = '0;
    for (int k = 0; k < NUIOOU; k++) begin
      if (bus.out_en && (bus.addr_out == AWOU'(k))) begin
        out_d[k] = bus.io_out;
        stb_d[k] = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUIOIN; i++) begin
        hold_q[i] <= '0;
        ovf_q[i]  <= '0;
      end
      for (int k = 0; k < NUIOOU; k++) begin
        out_q[k] <= '0;
      end
      fresh_q <= '0;
      stb_q   <= '0;
    end else begin
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
      fresh_q <= fresh_d;
      stb_q   <= stb_d;
    end
  end

  // Flatten the per-channel arrays onto the packed bus vectors.
  always_comb begin
    ovf_pk = '0;
    out_pk = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      ovf_pk[i*NBOVF +: NBOVF] = ovf_q[i];
    end
    for (int k = 0; k < NUIOOU; k++) begin
      out_pk[k*NBDATA +: NBDATA] = out_q[k];
    end
  end

  assign bus.io_in       = rd_data;
  assign bus.ch_in_fresh = fresh_q;
  assign bus.ch_out_data = out_pk;
  assign bus.ch_out_stb  = stb_q;
  assign bus.ovf_cnt     = ovf_pk;

endmodule

// File: tb/tb_proc_io_hub.sv
// tb_proc_io_hub
//  Drives a default-sized hub with directed and random traffic, checking it
//  every cycle against a behavioural model, plus a small hub (6 in, 6 out,
//  2-bit counters) for out-of-range addresses and counter saturation.
module tb_proc_io_hub;
  localparam int NB   = 23;
  localparam int NIN  = 8;
  localparam int NOU  = 8;
  localparam int NOVF = 8;
  localparam int OVFMAX = (1 << NOVF) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sRst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   checkEn = 1'b0;

  always #5 clk = ~clk;

  proc_io_hub_if #(.NBDATA(NB), .NUIOIN(NIN), .NUIOOU(NOU), .NBOVF(NOVF)) hubIf ();
  proc_io_hub_if #(.NBDATA(NB), .NUIOIN(6), .NUIOOU(6), .NBOVF(2)) sIf ();

  proc_io_hub #(.NBDATA(NB), .NUIOIN(NIN), .NUIOOU(NOU), .NBOVF(NOVF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hubIf.slave)
  );

  proc_io_hub #(.NBDATA(NB), .NUIOIN(6), .NUIOOU(6), .NBOVF(2)) dutSmall (
    .clk (clk),
    .rst (sRst),
    .bus (sIf.slave)
  );

  // Behavioural model: what the hub must hold after each rising edge.
  logic [NB-1:0] mHold [NIN];
  bit   [NIN-1:0] mFresh;
  int            mOvf  [NIN];
  logic [NB-1:0] mOut  [NOU];
  bit   [NOU-1:0] mStb;
  bit            mRd;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NIN; i++) begin mHold[i] = '0; mOvf[i] = 0; end
      for (int k = 0; k < NOU; k++) mOut[k] = '0;
      mFresh = '0;
      mStb   = '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        mRd = hubIf.req_in && (int'(hubIf.addr_in) == i);
        if (hubIf.ch_in_vld[i]) begin
          if (mFresh[i] && !mRd && mOvf[i] < OVFMAX) mOvf[i] = mOvf[i] + 1;
          mHold[i]  = hubIf.ch_in_data[i*NB +: NB];
          mFresh[i] = 1'b1;
        end else if (mRd) begin
          mFresh[i] = 1'b0;
        end
      end
      if (hubIf.ovf_clr) for (int i = 0; i < NIN; i++) mOvf[i] = 0;
      mStb = '0;
      if (hubIf.out_en && int'(hubIf.addr_out) < NOU) begin
        mOut[hubIf.addr_out] = hubIf.io_out;
        mStb[hubIf.addr_out] = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare of every hub output against the model.
  logic [NB-1:0]      expIo;
  logic [NIN*NOVF-1:0] expOvf;
  logic [NOU*NB-1:0]  expOut;

  always @(negedge clk) begin
    if (checkEn) begin
      expIo = (int'(hubIf.addr_in) < NIN) ? mHold[hubIf.addr_in] : '0;
      for (int i = 0; i < NIN; i++) expOvf[i*NOVF +: NOVF] = NOVF'(mOvf[i]);
      for (int k = 0; k < NOU; k++) expOut[k*NB +: NB] = mOut[k];
      checkOutput("model_io_in", hubIf.io_in, expIo);
      checkOutput("model_fresh", hubIf.ch_in_fresh, mFresh);
      checkOutput("model_out_data", hubIf.ch_out_data, expOut);
      checkOutput("model_out_stb", hubIf.ch_out_stb, mStb);
      checkOutput("model_ovf_cnt", hubIf.ovf_cnt, expOvf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of main-hub inputs; masked channels get 'word', others noise.
  task automatic applyStimulus(input logic [NIN-1:0] vld, input logic [NB-1:0] word,
                               input logic req, input logic [2:0] ain,
                               input logic oen, input logic [2:0] aout,
                               input logic [NB-1:0] wout, input logic clr);
    for (int i = 0; i < NIN; i++)
      hubIf.ch_in_data[i*NB +: NB] = vld[i] ? word : NB'($urandom);
    hubIf.ch_in_vld = vld;
    hubIf.req_in    = req;
    hubIf.addr_in   = ain;
    hubIf.out_en    = oen;
    hubIf.addr_out  = aout;
    hubIf.io_out    = wout;
    hubIf.ovf_clr   = clr;
  endtask

  task automatic idle(input logic [2:0] ain);
    applyStimulus('0, '0, 1'b0, ain, 1'b0, 3'd0, '0, 1'b0);
  endtask

  initial begin
    idle(3'd0);
    sIf.ch_in_data = '0;
    sIf.ch_in_vld  = '0;
    sIf.req_in     = 1'b0;
    sIf.addr_in    = '0;
    sIf.out_en     = 1'b0;
    sIf.addr_out   = '0;
    sIf.io_out     = '0;
    sIf.ovf_clr    = 1'b0;

    // Reset state
    tick();
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_fresh", hubIf.ch_in_fresh, 0);
    checkOutput("reset_stb", hubIf.ch_out_stb, 0);
    checkOutput("reset_ovf", hubIf.ovf_cnt, 0);
    checkOutput("reset_out_data", hubIf.ch_out_data, 0);
    tick();
    rst = 1'b0;

    // Capture on channel 2, then read it back the next cycle.
    applyStimulus(8'h04, 23'h12345, 1'b0, 3'd0, 1'b0, 3'd0, '0, 1'b0);
    tick();
    applyStimulus('0, '0, 1'b1, 3'd2, 1'b0, 3'd0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t1_io_in", hubIf.io_in, 23'h12345);
    checkOutput("t1_fresh_before", hubIf.ch_in_fresh[2], 1'b1);
    tick();
    idle(3'd2);
    @(negedge clk);
    checkOutput("t1_fresh_after", hubIf.ch_in_fresh[2], 1'b0);
    checkOutput("t1_ovf", hubIf.ovf_cnt[2*NOVF +: NOVF], 0);

    // Three unread samples on channel 5 -> two overruns.
    tick();
    applyStimulus(8'h20, 23'h00111, 1'b0, 3'd0, 1'b0, 3'd0, '0, 1'b0); tick();
    applyStimulus(8'h20, 23'h00222, 1'b0, 3'd0, 1'b0, 3'd0, '0, 1'b0); tick();
    applyStimulus(8'h20, 23'h00333, 1'b0, 3'd0, 1'b0, 3'd0, '0, 1'b0); tick();
    applyStimulus('0, '0, 1'b1, 3'd5, 1'b0, 3'd0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t2_ovf5", hubIf.ovf_cnt[5*NOVF +: NOVF], 2);
    checkOutput("t2_hold5", hubIf.io_in, 23'h00333);
    tick();

    // Read and new sample on the same cycle while channel 1 is fresh.
    applyStimulus(8'h02, 23'h00055, 1'b0, 3'd0, 1'b0, 3'd0, '0, 1'b0); tick();
    applyStimulus(8'h02, 23'h00AAA, 1'b1, 3'd1, 1'b0, 3'd0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t3_io_in_old", hubIf.io_in, 23'h00055);
    tick();
    idle(3'd1);
    @(negedge clk);
    checkOutput("t3_hold_new", hubIf.io_in, 23'h00AAA);
    checkOutput("t3_fresh1", hubIf.ch_in_fresh[1], 1'b1);
    checkOutput("t3_ovf1", hubIf.ovf_cnt[1*NOVF +: NOVF], 0);
    tick();

    // Output write to channel 3.
    applyStimulus('0, '0, 1'b0, 3'd0, 1'b1, 3'd3, 23'h7FFFF, 1'b0); tick();
    idle(3'd0);
    @(negedge clk);
    checkOutput("t4_out3", hubIf.ch_out_data[3*NB +: NB], 23'h7FFFF);
    checkOutput("t4_stb", hubIf.ch_out_stb, 8'b0000_1000);
    tick();
    @(negedge clk);
    checkOutput("t4_stb_clear", hubIf.ch_out_stb, 0);
    tick();

    // Random traffic, including occasional clears and resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NIN; i++) hubIf.ch_in_data[i*NB +: NB] = NB'($urandom);
      hubIf.ch_in_vld = NIN'($urandom & $urandom);
      hubIf.req_in    = 1'($urandom);
      hubIf.addr_in   = 3'($urandom);
      hubIf.out_en    = 1'($urandom);
      hubIf.addr_out  = 3'($urandom);
      hubIf.io_out    = NB'($urandom);
      hubIf.ovf_clr   = ($urandom_range(0, 63) == 0);
      rst             = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    // Reset mid-operation with fresh flags, strobes and a clear/overrun pending.
    applyStimulus(8'hFF, 23'h0ABCD, 1'b0, 3'd0, 1'b0, 3'd0, '0, 1'b0); tick();
    applyStimulus('0, '0, 1'b0, 3'd0, 1'b1, 3'd6, 23'h01234, 1'b0); tick();
    idle(3'd0);
    @(negedge clk);
    checkOutput("t6_pre_fresh", hubIf.ch_in_fresh, 8'hFF);
    checkOutput("t6_pre_stb", hubIf.ch_out_stb, 8'h40);
    applyStimulus(8'h01, 23'h00777, 1'b0, 3'd0, 1'b1, 3'd1, 23'h04444, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(3'd0);
    @(negedge clk);
    checkOutput("t6_rst_fresh", hubIf.ch_in_fresh, 0);
    checkOutput("t6_rst_stb", hubIf.ch_out_stb, 0);
    checkOutput("t6_rst_ovf", hubIf.ovf_cnt, 0);
    checkOutput("t6_rst_out", hubIf.ch_out_data, 0);
    checkOutput("t6_rst_hold", hubIf.io_in, 0);
    tick();

    // Clear beats a coincident overrun.
    applyStimulus(8'h01, 23'h00001, 1'b0, 3'd0, 1'b0, 3'd0, '0, 1'b0); tick();
    applyStimulus(8'h01, 23'h00002, 1'b0, 3'd0, 1'b0, 3'd0, '0, 1'b0); tick();
    applyStimulus(8'h01, 23'h00003, 1'b0, 3'd0, 1'b0, 3'd0, '0, 1'b0); tick();
    idle(3'd0);
    @(negedge clk);
    checkOutput("t6_ovf0_before", hubIf.ovf_cnt[0 +: NOVF], 2);
    applyStimulus(8'h01, 23'h00004, 1'b0, 3'd0, 1'b0, 3'd0, '0, 1'b1); tick();
    idle(3'd0);
    @(negedge clk);
    checkOutput("t6_ovf0_clr", hubIf.ovf_cnt[0 +: NOVF], 0);
    tick();

    // Small hub: saturation with 2-bit counters and out-of-range addresses.
    sRst = 1'b0;
    sIf.ch_in_data[0 +: NB] = 23'h00001;
    sIf.ch_in_vld = 6'b000001;
    repeat (6) tick();
    sIf.ch_in_vld = '0;
    sIf.req_in    = 1'b1;
    sIf.addr_in   = 3'd7;
    @(negedge clk);
    checkOutput("t2_small_sat", sIf.ovf_cnt[1:0], 2'd3);
    checkOutput("t5_io_in_oor", sIf.io_in, 0);
    tick();
    sIf.req_in   = 1'b0;
    sIf.addr_in  = 3'd0;
    sIf.out_en   = 1'b1;
    sIf.addr_out = 3'd7;
    sIf.io_out   = 23'h05A5A;
    @(negedge clk);
    checkOutput("t5_fresh_kept", sIf.ch_in_fresh, 6'b000001);
    checkOutput("t5_hold0", sIf.io_in, 23'h00001);
    tick();
    sIf.addr_out = 3'd6;
    @(negedge clk);
    checkOutput("t5_stb_oor7", sIf.ch_out_stb, 0);
    tick();
    sIf.out_en = 1'b0;
    @(negedge clk);
    checkOutput("t5_stb_oor6", sIf.ch_out_stb, 0);
    checkOutput("t5_out_oor", sIf.ch_out_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
